// File: rtl/enum_pkg.sv
// Shared encodings for the RV32M multiply/divide unit.
//   muldiv_op_t   : instruction funct3 for the M-extension ops
//   MULDIV_FUNCT7 : funct7 that selects the M-extension in OP instructions
//   md_state_t    : control states of the iterative unit
//   op_is_div     : true for DIV/DIVU/REM/REMU (funct3 bit 2)
package enum_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_t;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/rv_muldiv_negate.sv
// Conditional two's complement.
//   val_i : input value (W bits)
//   neg_i : 1 = negate, 0 = pass through
//   res_o : result, wraps modulo 2^W
module rv_muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? ((~val_i) + W'(1)) : val_i;

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Operands are reduced to magnitudes on acceptance, the core iterates XLEN
// steps on magnitudes, and the sign is reapplied in FIX.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start_i             : request, accepted when busy_o=0
//   op_i                : muldiv_op_t (funct3)
//   rs1_i, rs2_i        : operands
//   tag_i               : destination register tag
//   flush_i             : abort any in-flight op, drop a same-cycle request
//   busy_o              : op in flight (CALC or FIX)
//   done_o              : one-cycle completion strobe
//   result_o, tag_o     : result and tag of the last completed op (held)
module rv_muldiv_unit
  import enum_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t         state_q, state_d;
  muldiv_op_t        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [CW-1:0]     count_q, count_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  // Multiplicand (multiply) or divisor (divide), as a magnitude.
  logic [XLEN-1:0]   opnd_q, opnd_d;
  // Multiply: {high partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;

  muldiv_op_t        in_op;
  logic              in_sign_a, in_sign_b, div_zero, div_ovf;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign in_op = muldiv_op_t'(op_i);
  // rs1 is signed for MULH/MULHSU/DIV/REM, rs2 for MULH/DIV/REM. MUL is
  // treated as unsigned: its low half is sign-agnostic.
  assign in_sign_a = rs1_i[XLEN-1] &
                     (in_op == MULH || in_op == MULHSU || in_op == DIV || in_op == REM);
  assign in_sign_b = rs2_i[XLEN-1] &
                     (in_op == MULH || in_op == DIV || in_op == REM);
  assign div_zero  = op_is_div(in_op) && (rs2_i == '0);
  assign div_ovf   = (in_op == DIV || in_op == REM) && (rs1_i == MOST_NEG) && (&rs2_i);

  // Magnitudes fit in XLEN unsigned bits (|MOST_NEG| = 2^(XLEN-1)), so the
  // magnitude product plus a 2*XLEN-bit negate is exact for every sign mix,
  // including MULHSU with a negative rs1.
  rv_muldiv_negate #(.W(XLEN)) u_abs_a (.val_i(rs1_i), .neg_i(in_sign_a), .res_o(abs_a));
  rv_muldiv_negate #(.W(XLEN)) u_abs_b (.val_i(rs2_i), .neg_i(in_sign_b), .res_o(abs_b));

  // Shift-add step: add multiplicand into the high half, shift right by one.
  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, prod_q[XLEN-1:1]};

  // Restoring step: shift remainder left by one, trial subtract; a borrow
  // (MSB set) means restore and a quotient bit of 0.
  assign div_trial = prod_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
  assign div_next  = {(div_trial[XLEN] ? prod_q[2*XLEN-2:XLEN-1] : div_trial[XLEN-1:0]),
                      prod_q[XLEN-2:0], ~div_trial[XLEN]};

  rv_muldiv_negate #(.W(2*XLEN)) u_fix_prod (
    .val_i(prod_q), .neg_i(sign_a_q ^ sign_b_q), .res_o(prod_fix));
  rv_muldiv_negate #(.W(XLEN)) u_fix_quo (
    .val_i(prod_q[XLEN-1:0]), .neg_i(sign_a_q ^ sign_b_q), .res_o(quo_fix));
  rv_muldiv_negate #(.W(XLEN)) u_fix_rem (
    .val_i(prod_q[2*XLEN-1:XLEN]), .neg_i(sign_a_q), .res_o(rem_fix));

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    count_d   = count_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    opnd_d    = opnd_q;
    prod_d    = prod_q;
    result_d  = result_q;
    res_tag_d = res_tag_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i) begin
          op_d     = in_op;
          tag_d    = tag_i;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          count_d  = CW'(XLEN - 1);
          if (div_zero) begin
            state_d   = DONE;
            result_d  = in_op[1] ? rs1_i : '1;
            res_tag_d = tag_i;
          end else if (div_ovf) begin
            state_d   = DONE;
            result_d  = in_op[1] ? '0 : rs1_i;
            res_tag_d = tag_i;
          end else begin
            state_d = CALC;
            opnd_d  = op_is_div(in_op) ? abs_b : abs_a;
            prod_d  = {{XLEN{1'b0}}, (op_is_div(in_op) ? abs_a : abs_b)};
          end
        end
      end
      CALC: begin
        prod_d = op_is_div(op_q) ? div_next : mul_next;
        if (count_q == '0) state_d = FIX;
        else               count_d = count_q - CW'(1);
      end
      FIX: begin
        state_d   = DONE;
        res_tag_d = tag_q;
        case (op_q)
          MUL:                 result_d = prod_fix[XLEN-1:0];
          MULH, MULHSU, MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
          DIV, DIVU:           result_d = quo_fix;
          default:             result_d = rem_fix;
        endcase
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d   = IDLE;
      result_d  = result_q;
      res_tag_d = res_tag_q;
    end

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= MUL;
      tag_q     <= '0;
      count_q   <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      opnd_q    <= '0;
      prod_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      res_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      count_q   <= count_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      opnd_q    <= opnd_d;
      prod_q    <= prod_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      res_tag_q <= res_tag_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign tag_o    = res_tag_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed testbench for rv_muldiv_unit (XLEN=32, TAG_W=5).
// Cycle 0 is the cycle in which start_i is presented; outputs are sampled on
// the falling edge of each cycle.
module tb_rv_muldiv_unit;
  import enum_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  op_i = 3'b0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [4:0]  tag_i = '0;
  logic        busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  tag_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .tag_i(tag_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .tag_o(tag_o)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  // Present a request for one cycle, then scramble the inputs so that a unit
  // which fails to latch them produces a wrong answer. Returns in cycle 1.
  task automatic drive_start(input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] tg);
    op_i = op; rs1_i = a; rs2_i = b; tag_i = tg; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; op_i = ~op; rs1_i = 32'hDEAD_BEEF; rs2_i = 32'h0000_1234;
  endtask

  // Wait for done_o (bounded), checking busy_o each cycle. If poke_cyc is
  // non-zero, a fast-path request is thrown at the unit in that cycle and
  // must be ignored.
  task automatic wait_done(input string name, input logic [31:0] exp_res,
                           input logic [4:0] exp_tag, input int exp_cyc, input int poke_cyc);
    int   cyc = 1;
    int   seen = 0;
    int   busy_err = 0;
    logic exp_busy;
    while (seen == 0 && cyc <= 80) begin
      exp_busy = (exp_cyc > 1) && (cyc < exp_cyc);
      if (busy_o !== exp_busy) busy_err++;
      if (done_o === 1'b1) begin
        seen = cyc;
      end else begin
        start_i = (cyc == poke_cyc);
        if (cyc == poke_cyc) begin
          op_i = DIVU; rs1_i = 32'd1; rs2_i = 32'd0; tag_i = 5'd31;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start_i = 1'b0;
    $display("op %s: done_cycle=%0d result=0x%08h tag=%0d", name, seen, result_o, tag_o);
    check({name, "_cycle"}, seen, exp_cyc);
    check({name, "_result"}, result_o, exp_res);
    check({name, "_tag"}, {27'b0, tag_o}, {27'b0, exp_tag});
    check({name, "_busy"}, busy_err, 0);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tg, input logic [31:0] exp_res,
                        input int exp_cyc, input int poke_cyc);
    @(negedge clk);
    drive_start(op, a, b, tg);
    wait_done(name, exp_res, tg, exp_cyc, poke_cyc);
    @(negedge clk);
    check({name, "_pulse"}, {31'b0, done_o}, 32'd0);
  endtask

  initial begin
    int dones;

    // Reset values
    #12;
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_tag", {27'b0, tag_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiplies
    run_op("mul",    MUL,    32'd7,         32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 34, 0);
    run_op("mulh",   MULH,   32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 34, 0);
    run_op("mulhu",  MULHU,  32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000, 34, 0);
    run_op("mulhsu", MULHSU, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'hC000_0000, 34, 0);

    // Fast paths
    run_op("divu_z", DIVU, 32'd100,       32'd0,         5'd10, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_z", REMU, 32'd100,       32'd0,         5'd11, 32'd100,       1, 0);
    run_op("div_ov", DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, 0);
    run_op("rem_ov", REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1, 0);

    // Signed / unsigned divide
    run_op("div",  DIV,  32'hFFFF_FFF9, 32'd2, 5'd14, 32'hFFFF_FFFD, 34, 0);
    run_op("rem",  REM,  32'hFFFF_FFF9, 32'd2, 5'd15, 32'hFFFF_FFFF, 34, 0);
    run_op("divu", DIVU, 32'hFFFF_FFF9, 32'd2, 5'd8,  32'h7FFF_FFFC, 34, 0);

    // Flush in cycle 10 of a DIV
    @(negedge clk);
    drive_start(DIV, 32'd100, 32'd7, 5'd3);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_busy", {31'b0, busy_o}, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o === 1'b1) dones++;
      @(negedge clk);
    end
    $display("op flush: dones=%0d result=0x%08h tag=%0d", dones, result_o, tag_o);
    check("flush_nodone", dones, 0);
    check("flush_result", result_o, 32'h7FFF_FFFC);
    check("flush_tag", {27'b0, tag_o}, 32'd8);

    // Flush together with start in IDLE drops the request
    op_i = DIVU; rs1_i = 32'd1; rs2_i = 32'd0; tag_i = 5'd30;
    start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (done_o === 1'b1 || busy_o === 1'b1) dones++;
      @(negedge clk);
    end
    $display("op flush_start: activity=%0d result=0x%08h", dones, result_o);
    check("flstart_idle", dones, 0);
    check("flstart_result", result_o, 32'h7FFF_FFFC);

    // MUL with an ignored start in cycle 5
    run_op("mul_poke", MUL, 32'd3, 32'd5, 5'd9, 32'd15, 34, 5);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    drive_start(MUL, 32'd11, 32'd13, 5'd7);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("op reset_mid: busy=%0b done=%0b result=0x%08h tag=%0d", busy_o, done_o, result_o, tag_o);
    check("arst_busy", {31'b0, busy_o}, 32'd0);
    check("arst_done", {31'b0, done_o}, 32'd0);
    check("arst_result", result_o, 32'd0);
    check("arst_tag", {27'b0, tag_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back: second request presented in the DONE cycle
    @(negedge clk);
    drive_start(MUL, 32'd6, 32'd7, 5'd5);
    wait_done("b2b_a", 32'd42, 5'd5, 34, 0);
    drive_start(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    wait_done("b2b_b", 32'hFFFF_FFFE, 5'd6, 34, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
